// File: rtl/ffsr_update_arbiter_pkg.sv
// Shared types and helpers for the FFSR update arbiter: grant operation kind
// and the saturation limit of the shared pulse counter.
package ffsr_update_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_INC,
      OP_DEC
   } op_e;

   function automatic int unsigned maxCount(input int unsigned cntW);
      return (32'd1 << cntW) - 32'd1;
   endfunction

endpackage

// File: rtl/ffsr_update_arbiter_if.sv
// Bundle of requester pulses and arbiter results. The requester side is the
// master, the arbiter is the slave.
interface ffsr_update_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 3,
   parameter int ID_W  = $clog2(N_REQ)
);

   logic [N_REQ-1:0] req_inc;
   logic [N_REQ-1:0] req_dec;
   logic             ffsr_inc;
   logic             ffsr_dec;
   logic [CNT_W-1:0] count_o;
   logic             gnt_valid;
   logic [ID_W-1:0]  gnt_id;
   logic             sat_hi;
   logic             sat_lo;
   logic [N_REQ-1:0] drop;
   logic             busy;

   modport master (
      output req_inc, req_dec,
      input  ffsr_inc, ffsr_dec, count_o, gnt_valid, gnt_id,
             sat_hi, sat_lo, drop, busy
   );

   modport slave (
      input  req_inc, req_dec,
      output ffsr_inc, ffsr_dec, count_o, gnt_valid, gnt_id,
             sat_hi, sat_lo, drop, busy
   );

endinterface

// File: rtl/ffsr_update_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first pending requester at or after the
// pointer (with wrap-around) and advances the pointer past the winner.
module ffsr_update_arbiter_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] gnt_oh_o,
   output logic [ID_W-1:0]  gnt_id_o,
   output logic             gnt_valid_o
);

   logic [ID_W-1:0] rrPtr_q;
   logic [ID_W-1:0] rrPtr_d;

   always_comb begin
      gnt_oh_o    = '0;
      gnt_id_o    = '0;
      gnt_valid_o = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = int'(rrPtr_q) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!gnt_valid_o && req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_id_o    = ID_W'(idx);
         end
      end
      if (gnt_valid_o) begin
         gnt_oh_o[gnt_id_o] = 1'b1;
      end
   end

   // Pointer moves to one past the winner so it has lowest priority next time.
   always_comb begin
      rrPtr_d = rrPtr_q;
      if (gnt_valid_o) begin
         if (gnt_id_o == ID_W'(N_REQ - 1)) begin
            rrPtr_d = '0;
         end else begin
            rrPtr_d = gnt_id_o + ID_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrPtr_q <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end

endmodule

// File: rtl/ffsr_update_arbiter.sv
// Funnels per-requester inc/dec pulses onto one shared up/down counter,
// one strobe per cycle, saturating via a shadow count instead of wrapping.
module ffsr_update_arbiter
   import ffsr_update_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int CNT_W = 3,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   ffsr_update_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(maxCount(CNT_W));

   logic [N_REQ-1:0] pendInc_q, pendInc_d;
   logic [N_REQ-1:0] pendDec_q, pendDec_d;
   logic [N_REQ-1:0] drop_q, drop_d;
   logic [N_REQ-1:0] gntOH;
   logic [ID_W-1:0]  gntId;
   logic             gntValid;
   op_e              op;

   logic             ffsrInc_q, ffsrInc_d;
   logic             ffsrDec_q, ffsrDec_d;
   logic             satHi_q, satHi_d;
   logic             satLo_q, satLo_d;
   logic             gntValid_q;
   logic [ID_W-1:0]  gntId_q;
   logic [CNT_W-1:0] count_q, count_d;

   ffsr_update_arbiter_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .clk         (clk),
      .rst         (rst),
      .req_i       (pendInc_q | pendDec_q),
      .gnt_oh_o    (gntOH),
      .gnt_id_o    (gntId),
      .gnt_valid_o (gntValid)
   );

   // The grant consumes the old flag first, so a pulse arriving for the granted
   // requester simply becomes its new pending flag with no cancel or drop.
   always_comb begin
      pendInc_d = pendInc_q & ~gntOH;
      pendDec_d = pendDec_q & ~gntOH;
      drop_d    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req_inc[i] && !bus.req_dec[i]) begin
            if (pendDec_d[i]) begin
               pendDec_d[i] = 1'b0;
            end else if (pendInc_d[i]) begin
               drop_d[i] = 1'b1;
            end else begin
               pendInc_d[i] = 1'b1;
            end
         end else if (bus.req_dec[i] && !bus.req_inc[i]) begin
            if (pendInc_d[i]) begin
               pendInc_d[i] = 1'b0;
            end else if (pendDec_d[i]) begin
               drop_d[i] = 1'b1;
            end else begin
               pendDec_d[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      op = OP_NONE;
      if (gntValid) begin
         op = (|(gntOH & pendInc_q)) ? OP_INC : OP_DEC;
      end
   end

   always_comb begin
      ffsrInc_d = 1'b0;
      ffsrDec_d = 1'b0;
      satHi_d   = 1'b0;
      satLo_d   = 1'b0;
      count_d   = count_q;
      unique case (op)
         OP_INC: begin
            if (count_q != CNT_MAX) begin
               ffsrInc_d = 1'b1;
               count_d   = count_q + CNT_W'(1);
            end else begin
               satHi_d = 1'b1;
            end
         end
         OP_DEC: begin
            if (count_q != '0) begin
               ffsrDec_d = 1'b1;
               count_d   = count_q - CNT_W'(1);
            end else begin
               satLo_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pendInc_q  <= '0;
         pendDec_q  <= '0;
         drop_q     <= '0;
         ffsrInc_q  <= 1'b0;
         ffsrDec_q  <= 1'b0;
         satHi_q    <= 1'b0;
         satLo_q    <= 1'b0;
         gntValid_q <= 1'b0;
         gntId_q    <= '0;
         count_q    <= '0;
      end else begin
         pendInc_q  <= pendInc_d;
         pendDec_q  <= pendDec_d;
         drop_q     <= drop_d;
         ffsrInc_q  <= ffsrInc_d;
         ffsrDec_q  <= ffsrDec_d;
         satHi_q    <= satHi_d;
         satLo_q    <= satLo_d;
         gntValid_q <= gntValid;
         gntId_q    <= gntId;
         count_q    <= count_d;
      end
   end

   assign bus.ffsr_inc  = ffsrInc_q;
   assign bus.ffsr_dec  = ffsrDec_q;
   assign bus.sat_hi    = satHi_q;
   assign bus.sat_lo    = satLo_q;
   assign bus.gnt_valid = gntValid_q;
   assign bus.gnt_id    = gntId_q;
   assign bus.count_o   = count_q;
   assign bus.drop      = drop_q;
   assign bus.busy      = |(pendInc_q | pendDec_q);

endmodule
